// File: rtl/downstream_vc_tracker.sv
// Downstream VC credit and ownership tracker.
// Feeds idle and credit-available vectors to the VC/switch allocators.
module downstream_vc_tracker #(
  parameter int VC_TOTAL    = 10,
  parameter int PORT_NUM    = 5,
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [VC_TOTAL-1:0] vc_allocated_i,
  input  logic [VC_TOTAL-1:0] flit_sent_i,
  input  logic [VC_TOTAL-1:0] tail_sent_i,
  input  logic [VC_TOTAL-1:0] credit_i,
  output logic [VC_TOTAL-1:0] idle_downstream_vc_o,
  output logic [VC_TOTAL-1:0] credit_available_o,
  output logic                error_o
);

  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAINING
  } vc_state_t;

  // VC index d maps to port d/VC_NUM, so the totals must agree.
  if (VC_TOTAL != PORT_NUM * VC_NUM) begin : g_bad_cfg
    $error("VC_TOTAL must equal PORT_NUM*VC_NUM");
  end

  vc_state_t           st_q  [VC_TOTAL];
  vc_state_t           st_d  [VC_TOTAL];
  logic [CW-1:0]       cnt_q [VC_TOTAL];
  logic [CW-1:0]       cnt_d [VC_TOTAL];
  logic [VC_TOTAL-1:0] send_ok;
  logic [VC_TOTAL-1:0] cred_ok;
  logic [VC_TOTAL-1:0] viol;
  logic [VC_TOTAL-1:0] idle_q, idle_d;
  logic [VC_TOTAL-1:0] avail_q, avail_d;
  logic                err_q;

  // Per-VC acceptance, counter update, state transition, violations.
  always_comb begin
    send_ok = '0;
    cred_ok = '0;
    viol    = '0;
    idle_d  = '0;
    avail_d = '0;
    for (int d = 0; d < VC_TOTAL; d++) begin
      st_d[d]  = st_q[d];
      cnt_d[d] = cnt_q[d];

      send_ok[d] = flit_sent_i[d]
                 && (st_q[d] == ACTIVE)
                 && ((cnt_q[d] != '0) || credit_i[d]);
      cred_ok[d] = credit_i[d]
                 && ((cnt_q[d] != FULL) || send_ok[d]);

      viol[d] = (flit_sent_i[d] && !send_ok[d])
              || (credit_i[d] && !cred_ok[d])
              || (vc_allocated_i[d] && (st_q[d] != IDLE));

      cnt_d[d] = cnt_q[d]
               - CW'(send_ok[d])
               + CW'(cred_ok[d]);

      unique case (st_q[d])
        IDLE: begin
          if (vc_allocated_i[d]) st_d[d] = ACTIVE;
        end
        ACTIVE: begin
          if (send_ok[d] && tail_sent_i[d])
            st_d[d] = (cnt_d[d] == FULL) ? IDLE : DRAINING;
        end
        DRAINING: begin
          if (cnt_d[d] == FULL) st_d[d] = IDLE;
        end
        default: st_d[d] = IDLE;
      endcase

      idle_d[d]  = (st_d[d] == IDLE);
      avail_d[d] = (cnt_d[d] != '0);
    end
  end

  // State, counters and registered outputs; error is sticky until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < VC_TOTAL; d++) begin
        st_q[d]  <= IDLE;
        cnt_q[d] <= FULL;
      end
      idle_q  <= '1;
      avail_q <= '1;
      err_q   <= 1'b0;
    end else begin
      for (int d = 0; d < VC_TOTAL; d++) begin
        st_q[d]  <= st_d[d];
        cnt_q[d] <= cnt_d[d];
      end
      idle_q  <= idle_d;
      avail_q <= avail_d;
      err_q   <= err_q | (|viol);
    end
  end

  assign idle_downstream_vc_o = idle_q;
  assign credit_available_o   = avail_q;
  assign error_o              = err_q;

endmodule

// File: tb/tb_downstream_vc_tracker.sv
// Randomized + directed bench for downstream_vc_tracker.
// Outputs compared at negedge against a credit/ownership model.
module tb_downstream_vc_tracker;

  localparam int VCT = 10;
  localparam int BS  = 8;
  localparam logic [VCT-1:0] ALL1 = '1;

  logic           clk;
  logic           rst;
  logic [VCT-1:0] alloc, sent, tail, cred;
  logic [VCT-1:0] idle_o, avail_o;
  logic           err_o;

  int n_chk;
  int n_fail;

  // model: credits held per VC, ownership phase, sticky error
  int m_cred [VCT];
  int m_own  [VCT];
  bit m_err;

  downstream_vc_tracker #(
    .VC_TOTAL(VCT),
    .PORT_NUM(5),
    .VC_NUM(2),
    .BUFFER_SIZE(BS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vc_allocated_i(alloc),
    .flit_sent_i(sent),
    .tail_sent_i(tail),
    .credit_i(cred),
    .idle_downstream_vc_o(idle_o),
    .credit_available_o(avail_o),
    .error_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // ownership: 0 free, 1 owned by a packet, 2 waiting for credits
  task automatic model_step();
    if (rst) begin
      for (int d = 0; d < VCT; d++) begin
        m_cred[d] = BS;
        m_own[d]  = 0;
      end
      m_err = 0;
      return;
    end
    for (int d = 0; d < VCT; d++) begin
      int  c;
      int  o;
      bit  go;
      bit  back;
      c  = m_cred[d];
      o  = m_own[d];
      go = sent[d] && o == 1 && (c > 0 || cred[d]);
      back = cred[d] && (c < BS || go);
      if (sent[d] && !go) m_err = 1;
      if (cred[d] && !back) m_err = 1;
      if (alloc[d] && o != 0) m_err = 1;
      c = c + (back ? 1 : 0) - (go ? 1 : 0);
      if (o == 0 && alloc[d]) o = 1;
      else if (o == 1 && go && tail[d]) o = (c == BS) ? 0 : 2;
      else if (o == 2 && c == BS) o = 0;
      m_cred[d] = c;
      m_own[d]  = o;
    end
  endtask

  task automatic check_all(input string tag);
    logic [VCT-1:0] ei, ea;
    for (int d = 0; d < VCT; d++) begin
      ei[d] = (m_own[d] == 0);
      ea[d] = (m_cred[d] > 0);
    end
    chk({tag, "_idle"}, 32'(idle_o), 32'(ei));
    chk({tag, "_avail"}, 32'(avail_o), 32'(ea));
    chk({tag, "_err"}, 32'(err_o), 32'(m_err));
  endtask

  // apply one cycle of inputs, update model at the edge, compare at negedge
  task automatic step(input logic [VCT-1:0] a,
                      input logic [VCT-1:0] s,
                      input logic [VCT-1:0] t,
                      input logic [VCT-1:0] c);
    alloc = a;
    sent  = s;
    tail  = t;
    cred  = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    alloc = '0;
    sent  = '0;
    tail  = '0;
    cred  = '0;
    check_all("cyc");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step('0, '0, '0, '0);
    rst = 1'b0;
    chk("rst_idle", 32'(idle_o), 32'(ALL1));
    chk("rst_avail", 32'(avail_o), 32'(ALL1));
    chk("rst_err", 32'(err_o), 32'd0);
  endtask

  localparam logic [VCT-1:0] V0 = 1;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    alloc  = '0;
    sent   = '0;
    tail   = '0;
    cred   = '0;
    @(negedge clk);
    do_reset();

    // idle after reset
    for (int i = 0; i < 3; i++) step('0, '0, '0, '0);
    chk("idle3_idle", 32'(idle_o), 32'(ALL1));
    chk("idle3_avail", 32'(avail_o), 32'(ALL1));
    chk("idle3_err", 32'(err_o), 32'd0);

    // VC3: allocate, drain all credits, then underflow
    step(V0 << 3, '0, '0, '0);
    chk("vc3_alloc_idle", 32'(idle_o[3]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step('0, V0 << 3, '0, '0);
      if (i == 6) chk("vc3_7th_avail", 32'(avail_o[3]), 32'd1);
    end
    chk("vc3_8th_avail", 32'(avail_o[3]), 32'd0);
    chk("vc3_8th_err", 32'(err_o), 32'd0);
    step('0, V0 << 3, '0, '0);
    chk("vc3_9th_err", 32'(err_o), 32'd1);
    chk("vc3_9th_avail", 32'(avail_o[3]), 32'd0);
    step('0, '0, '0, V0 << 3);
    chk("vc3_cred_avail", 32'(avail_o[3]), 32'd1);
    do_reset();

    // VC0: tail then a late credit releases the VC
    step(V0, '0, '0, '0);
    step('0, V0, V0, '0);
    chk("vc0_drain_idle", 32'(idle_o[0]), 32'd0);
    step('0, '0, '0, '0);
    chk("vc0_wait_idle", 32'(idle_o[0]), 32'd0);
    step('0, '0, '0, V0);
    chk("vc0_free_idle", 32'(idle_o[0]), 32'd1);
    chk("vc0_err", 32'(err_o), 32'd0);

    // VC5: send+credit together leaves the count at 4
    step(V0 << 5, '0, '0, '0);
    for (int i = 0; i < 4; i++) step('0, V0 << 5, '0, '0);
    for (int i = 0; i < 5; i++) step('0, V0 << 5, '0, V0 << 5);
    chk("vc5_avail", 32'(avail_o[5]), 32'd1);
    chk("vc5_err", 32'(err_o), 32'd0);
    for (int i = 0; i < 3; i++) step('0, V0 << 5, '0, '0);
    chk("vc5_3more_avail", 32'(avail_o[5]), 32'd1);
    step('0, V0 << 5, '0, '0);
    chk("vc5_4more_avail", 32'(avail_o[5]), 32'd0);
    do_reset();

    // VC7 double allocation, then credit overflow on idle VC2
    step(V0 << 7, '0, '0, '0);
    chk("vc7_first_err", 32'(err_o), 32'd0);
    step(V0 << 7, '0, '0, '0);
    chk("vc7_second_err", 32'(err_o), 32'd1);
    chk("vc7_second_idle", 32'(idle_o[7]), 32'd0);
    step('0, '0, '0, V0 << 2);
    chk("vc2_ovf_err", 32'(err_o), 32'd1);
    chk("vc2_ovf_avail", 32'(avail_o[2]), 32'd1);
    step('0, V0 << 7, V0 << 7, '0);
    chk("vc7_tail_idle", 32'(idle_o[7]), 32'd0);
    step('0, '0, '0, V0 << 7);
    chk("vc7_back_idle", 32'(idle_o[7]), 32'd1);
    do_reset();

    // randomized traffic, mostly legal, with periodic rst
    for (int i = 0; i < 3000; i++) begin
      logic [VCT-1:0] a, s, t, c;
      if (i % 400 == 399) begin
        // drive traffic alongside rst: rst must win
        rst = 1'b1;
        step('1, '1, '1, '1);
        rst = 1'b0;
        chk("rnd_rst_idle", 32'(idle_o), 32'(ALL1));
        chk("rnd_rst_avail", 32'(avail_o), 32'(ALL1));
        chk("rnd_rst_err", 32'(err_o), 32'd0);
        continue;
      end
      for (int d = 0; d < VCT; d++) begin
        a[d] = (m_own[d] == 0 && $urandom_range(5) == 0)
            || $urandom_range(299) == 0;
        s[d] = (m_own[d] == 1 && m_cred[d] > 0
                && $urandom_range(2) == 0)
            || $urandom_range(299) == 0;
        t[d] = ($urandom_range(3) == 0);
        c[d] = (m_cred[d] < BS && $urandom_range(2) == 0)
            || $urandom_range(399) == 0;
      end
      step(a, s, t, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
